// File: rtl/sample_clk_monitor.sv
// sample_clk_monitor
//   Receive side of the divided sample clock. The asynchronous inClk is
//   brought into the clk domain through a three-flop chain. One-cycle
//   rise/fall strobes are produced for the filter datapath. Every half-period
//   is measured in clk cycles, and a lock FSM tracks whether the measurement
//   stays inside the tolerance window. A sticky loss flag records any drop
//   out of lock.
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous reset, active-low
//   inClk         in   divided sample clock, asynchronous to clk
//   clrErr        in   one-cycle pulse that clears lossErr
//   sampleStrobe  out  one-cycle pulse per inClk rising edge
//   fallStrobe    out  one-cycle pulse per inClk falling edge
//   halfPeriod    out  last accepted half-period measurement, in clk cycles
//   locked        out  high while the FSM is in LOCKED (one cycle behind the state)
//   lossErr       out  sticky, set when LOCKED is left for LOST
module sample_clk_monitor #(
  parameter int CNT_W    = 16,
  parameter int NOM_HALF = 261,
  parameter int TOL      = 4,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 522
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inClk,
  input  logic             clrErr,
  output logic             sampleStrobe,
  output logic             fallStrobe,
  output logic [CNT_W-1:0] halfPeriod,
  output logic             locked,
  output logic             lossErr
);

  localparam int GC_W = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] GOOD_LO      = CNT_W'(NOM_HALF - TOL);
  localparam logic [CNT_W-1:0] GOOD_HI      = CNT_W'(NOM_HALF + TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [GC_W-1:0]  LOCK_LAST    = GC_W'(LOCK_CNT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    LOST   = 2'd3
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [GC_W-1:0]   good_cnt_reg;
  logic [GC_W-1:0]   good_cnt_next;
  logic [CNT_W-1:0]  half_cnt_reg;
  logic [CNT_W-1:0]  meas;
  logic              s1;
  logic              s2;
  logic              s3;
  logic              edge_hit;
  logic              rise;
  logic              fall;
  logic              good;
  logic              timeout;
  logic              capture;
  logic              loss_set;

  // s1 is the metastability catcher; edges are detected between s2 and s3.
  assign edge_hit = s2 ^ s3;
  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;

  // Measurement includes the edge cycle itself, so a toggle every N clks
  // yields meas == N. Saturates so a stalled clock never wraps to a "good" value.
  assign meas    = (half_cnt_reg == CNT_MAX) ? CNT_MAX : half_cnt_reg + CNT_W'(1);
  assign good    = (meas >= GOOD_LO) && (meas <= GOOD_HI);
  assign timeout = !edge_hit && (half_cnt_reg == TIMEOUT_LAST);

  // Synchroniser, strobes and half-period counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      sampleStrobe <= 1'b0;
      fallStrobe   <= 1'b0;
      half_cnt_reg <= '0;
    end else begin
      s1           <= inClk;
      s2           <= s1;
      s3           <= s2;
      sampleStrobe <= rise;
      fallStrobe   <= fall;
      if (edge_hit) begin
        half_cnt_reg <= '0;
      end else if (half_cnt_reg != CNT_MAX) begin
        half_cnt_reg <= half_cnt_reg + CNT_W'(1);
      end
    end
  end

  // FSM state register (plus the acquisition counter that travels with it).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      good_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      good_cnt_reg <= good_cnt_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (edge_hit) state_next = ACQ;
      end
      ACQ: begin
        if (edge_hit) begin
          if (good && (good_cnt_reg == LOCK_LAST)) state_next = LOCKED;
        end else if (timeout) begin
          state_next = IDLE;
        end
      end
      LOCKED: begin
        if ((edge_hit && !good) || timeout) state_next = LOST;
      end
      LOST: begin
        if (edge_hit) state_next = ACQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM output logic: acquisition count, measurement capture, loss event.
  // Measurements taken in IDLE/LOST span a gap and are thrown away.
  always_comb begin
    good_cnt_next = good_cnt_reg;
    capture       = 1'b0;
    loss_set      = 1'b0;
    case (state_reg)
      IDLE, LOST: begin
        if (edge_hit) good_cnt_next = '0;
      end
      ACQ: begin
        if (edge_hit) begin
          capture       = 1'b1;
          good_cnt_next = good ? good_cnt_reg + GC_W'(1) : '0;
        end
      end
      LOCKED: begin
        capture  = edge_hit;
        loss_set = (edge_hit && !good) || timeout;
      end
      default: ;
    endcase
  end

  // Registered outputs. A loss in the same cycle as clrErr wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      halfPeriod <= '0;
      locked     <= 1'b0;
      lossErr    <= 1'b0;
    end else begin
      if (capture) halfPeriod <= meas;
      locked <= (state_reg == LOCKED);
      if (loss_set) begin
        lossErr <= 1'b1;
      end else if (clrErr) begin
        lossErr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_clk_monitor.sv
// Testbench for sample_clk_monitor.
// The stimulus process drives inClk as a sequence of half-periods (in clk
// cycles). Before each half-period is played out, a half-period-level model
// predicts every visible consequence with the cycle it appears on:
//   - one strobe record per inClk edge (direction, halfPeriod, locked, lossErr)
//   - change events for locked and lossErr (from lock, loss, timeout, clear, reset)
// A monitor samples the DUT on the falling clk edge and compares against the
// queues whenever a strobe fires or locked/lossErr changes.
module tb_sample_clk_monitor;

  localparam int NOM   = 261;
  localparam int TOL   = 4;
  localparam int LOCKN = 4;
  localparam int TMO   = 522;

  localparam int M_IDLE   = 0;
  localparam int M_ACQ    = 1;
  localparam int M_LOCKED = 2;
  localparam int M_LOST   = 3;

  logic        clk;
  logic        rst;
  logic        inClk;
  logic        clrErr;
  logic        sampleStrobe;
  logic        fallStrobe;
  logic [15:0] halfPeriod;
  logic        locked;
  logic        lossErr;

  sample_clk_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .inClk       (inClk),
    .clrErr      (clrErr),
    .sampleStrobe(sampleStrobe),
    .fallStrobe  (fallStrobe),
    .halfPeriod  (halfPeriod),
    .locked      (locked),
    .lossErr     (lossErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit rise;
    int hp;
    bit lk;
    bit le;
  } strobe_t;

  typedef struct {
    int cyc;
    bit val;
  } chg_t;

  strobe_t sq[$];
  chg_t    lkq[$];
  chg_t    leq[$];

  int checks = 0;
  int errors = 0;

  // Model state.
  int m_state = M_IDLE;
  int m_gc    = 0;
  int m_hp    = 0;
  int m_ref   = 0;   // cycle of the last edge action or reset
  bit m_lk    = 1'b0;
  bit m_le    = 1'b0;
  int pend_clr = 0;  // clr offset belonging to the most recent toggle

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push_lk(input int c, input bit v);
    if (v != m_lk) begin
      lkq.push_back('{c, v});
      m_lk = v;
    end
  endtask

  task automatic push_le(input int c, input bit v);
    if (v != m_le) begin
      leq.push_back('{c, v});
      m_le = v;
    end
  endtask

  function automatic bit is_good(input int m);
    return (m >= NOM - TOL) && (m <= NOM + TOL);
  endfunction

  task automatic model_reset(input int r);
    push_lk(r, 1'b0);
    push_le(r, 1'b0);
    m_state = M_IDLE;
    m_gc    = 0;
    m_hp    = 0;
    m_ref   = r;
  endtask

  // act: cycle on which the DUT reacts to this inClk edge.
  task automatic model_toggle(input int act, input bit level, input int clr_off);
    int meas;
    bit was_locked;
    bit set;
    if (act - m_ref > TMO) begin
      if (m_state == M_ACQ) begin
        m_state = M_IDLE;
      end else if (m_state == M_LOCKED) begin
        m_state = M_LOST;
        push_le(m_ref + TMO, 1'b1);
        push_lk(m_ref + TMO + 1, 1'b0);
      end
    end
    meas = act - m_ref;
    if (meas > 65535) meas = 65535;
    was_locked = (m_state == M_LOCKED);
    set = 1'b0;
    case (m_state)
      M_ACQ: begin
        m_hp = meas;
        if (is_good(meas)) begin
          m_gc++;
          if (m_gc == LOCKN) begin
            m_state = M_LOCKED;
            push_lk(act + 1, 1'b1);
          end
        end else begin
          m_gc = 0;
        end
      end
      M_LOCKED: begin
        m_hp = meas;
        if (!is_good(meas)) begin
          m_state = M_LOST;
          set = 1'b1;
          push_lk(act + 1, 1'b0);
        end
      end
      default: begin
        m_state = M_ACQ;
        m_gc = 0;
      end
    endcase
    if (set) push_le(act, 1'b1);
    else if (clr_off == 2) push_le(act, 1'b0);
    sq.push_back('{act, level, m_hp, was_locked, m_le});
    if (clr_off == 3) push_le(act + 1, 1'b0);
    m_ref = act;
  endtask

  // Play one half-period of h clks, then toggle inClk. clr_off (2 or 3)
  // schedules a clrErr pulse aligned with, or one cycle after, the DUT's
  // reaction to this toggle. rst_off > 0 pulses rst low mid-half-period.
  task automatic step(input int h, input int clr_off, input int rst_off);
    int n;
    n = cyc;
    if (rst_off > 0) model_reset(n + rst_off + 1);
    model_toggle(n + h + 3, !inClk, clr_off);
    for (int i = 1; i <= h; i++) begin
      @(negedge clk);
      clrErr = (i == pend_clr);
      rst    = (i != rst_off);
      if (rst_off > 0 && i == rst_off + 1) begin
        chk("rst_halfPeriod", halfPeriod, 0);
        chk("rst_sampleStrobe", sampleStrobe, 0);
        chk("rst_fallStrobe", fallStrobe, 0);
        chk("rst_locked", locked, 0);
        chk("rst_lossErr", lossErr, 0);
      end
    end
    inClk = ~inClk;
    pend_clr = clr_off;
  endtask

  // Monitor / scoreboard.
  bit      mon_en = 1'b0;
  bit      prev_lk = 1'b0;
  bit      prev_le = 1'b0;
  strobe_t mon_s;
  chg_t    mon_c;

  always @(negedge clk) begin
    if (mon_en) begin
      if (sampleStrobe || fallStrobe) begin
        if (sq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL strobe_unexpected at cyc %0d: got rise=%0b fall=%0b expected none",
                   cyc, sampleStrobe, fallStrobe);
        end else begin
          mon_s = sq.pop_front();
          chk("strobe_cycle", cyc, mon_s.cyc);
          chk("sampleStrobe", sampleStrobe, mon_s.rise);
          chk("fallStrobe", fallStrobe, !mon_s.rise);
          chk("halfPeriod", halfPeriod, mon_s.hp);
          chk("locked_at_strobe", locked, mon_s.lk);
          chk("lossErr_at_strobe", lossErr, mon_s.le);
          $display("strobe cyc=%0d dir=%s halfPeriod=%0d locked=%0b lossErr=%0b",
                   cyc, sampleStrobe ? "rise" : "fall", halfPeriod, locked, lossErr);
        end
      end
      if (locked !== prev_lk) begin
        if (lkq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL locked_unexpected at cyc %0d: got %0b expected no change", cyc, locked);
        end else begin
          mon_c = lkq.pop_front();
          chk("locked_change_cycle", cyc, mon_c.cyc);
          chk("locked_change_value", locked, mon_c.val);
        end
        prev_lk = locked;
      end
      if (lossErr !== prev_le) begin
        if (leq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL lossErr_unexpected at cyc %0d: got %0b expected no change", cyc, lossErr);
        end else begin
          mon_c = leq.pop_front();
          chk("lossErr_change_cycle", cyc, mon_c.cyc);
          chk("lossErr_change_value", lossErr, mon_c.val);
        end
        prev_le = lossErr;
      end
    end
  end

  initial begin
    rst    = 1'b0;
    inClk  = 1'b0;
    clrErr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_sampleStrobe", sampleStrobe, 0);
    chk("reset_fallStrobe", fallStrobe, 0);
    chk("reset_halfPeriod", halfPeriod, 0);
    chk("reset_locked", locked, 0);
    chk("reset_lossErr", lossErr, 0);
    m_ref  = cyc;
    rst    = 1'b1;
    mon_en = 1'b1;

    // Nominal toggling: first edge discarded, four good edges lock.
    for (int k = 0; k < 7; k++) step(NOM, 0, 0);

    // Tolerance edges while locked.
    step(265, 0, 0);
    step(266, 0, 0);
    for (int k = 0; k < 6; k++) step(NOM, 0, 0);

    // Stopped clock: timeout loss, long hold, then relock.
    step(1200, 0, 0);
    for (int k = 0; k < 5; k++) step(NOM, 0, 0);
    step(NOM, 3, 0);

    // Loss with simultaneous clear, clear a cycle later, acquisition restart.
    step(200, 2, 0);
    step(NOM, 3, 0);
    for (int k = 0; k < 3; k++) step(NOM, 0, 0);
    step(200, 0, 0);
    for (int k = 0; k < 5; k++) step(NOM, 0, 0);

    // Reset while locked, mid-half-period, with inClk low.
    if (inClk) step(NOM, 0, 0);
    step(150, 0, 60);
    for (int k = 0; k < 6; k++) step(NOM, 0, 0);

    // Randomized half-periods: mostly near nominal, with glitches,
    // gross errors, stalls and clear pulses mixed in.
    for (int k = 0; k < 80; k++) begin
      int r;
      int h;
      int c;
      r = int'($urandom_range(0, 19));
      if (r == 0)      h = int'($urandom_range(1, 3));
      else if (r == 1) h = 200;
      else if (r == 2) h = int'($urandom_range(523, 560));
      else             h = int'($urandom_range(255, 268));
      if (h < pend_clr) h = pend_clr;
      c = int'($urandom_range(0, 5));
      c = (c == 0) ? 2 : ((c == 1) ? 3 : 0);
      step(h, c, 0);
    end

    // Drain: let the final edge and any pending clear play out.
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      clrErr = (i == pend_clr);
    end
    clrErr = 1'b0;

    chk("strobe_queue_empty", sq.size(), 0);
    chk("locked_queue_empty", lkq.size(), 0);
    chk("lossErr_queue_empty", leq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
